mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access engine. Sits between EX/MEM pipeline register and MEM/WB register.
//  Turns EX/MEM load/store controls into a req/ack data-bus transaction with byte enables.
//  Returns sign/zero-extended load data as MemoryData and holds the pipeline via MEMStall until the access completes.
//  Flags misaligned or illegal accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max BUSY cycles without mem_ack before abort; 0 disables timeout (8-bit counter)
// PORTS
//  clk             in   1   clock, all state updates on posedge
//  rst             in   1   reset: asynchronous, active-low
//  EXMEMMemRead    in   1   load in MEM stage
//  EXMEMMemWrite   in   1   store in MEM stage
//  EXMEMFunct3     in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (stores use B/H/W)
//  EXMEMALUResult  in   32  byte address
//  EXMEMWriteData  in   32  store data (rs2)
//  MEMHold         in   1   downstream hold; keeps DONE state and outputs
//  mem_req         out  1   bus request, held until mem_ack or abort
//  mem_we          out  1   1 = write
//  mem_addr        out  32  word address {addr[31:2],2'b00}
//  mem_be          out  4   byte enables
//  mem_wdata       out  32  lane-replicated store data
//  mem_ack         in   1   completion; sampled only while mem_req=1
//  mem_rdata       in   32  read word, valid with mem_ack
//  MemoryData      out  32  extended load result, to MEM/WB register
//  MEMStall        out  1   freeze PC/IF/ID/EX/EXMEM
//  MisalignErr     out  1   misaligned or illegal funct3 access, high in DONE
//  BusTimeout      out  1   timeout abort, high in DONE
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0; timeout counter 0. Mid-transaction reset drops mem_req immediately.
//  States: IDLE, BUSY, DONE.
//  IDLE: access = MemRead|MemWrite. No access -> stay IDLE, MEMStall=0, MemoryData holds.
//   Access -> MEMStall=1 (combinational, same cycle). Latch addr, funct3, we, be, wdata.
//   Aligned + legal -> BUSY. Else -> DONE with MisalignErr=1 and no bus cycle.
//  Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. Illegal: funct3 011/110/111, or BU/HU on a store.
//  BUSY: registered mem_req=1; mem_we/addr/be/wdata stable. MEMStall=1. Counter increments each cycle.
//   mem_ack -> mem_req=0 next cycle, go DONE. On a read, MemoryData <= extend(mem_rdata).
//   Counter reaches TIMEOUT_CYCLES without ack -> mem_req=0, MemoryData=0, BusTimeout=1, go DONE.
//   Ack and timeout in the same cycle: ack wins.
//  DONE: MEMStall=0; MemoryData and flags valid. EX/MEM advances at this edge.
//   MEMHold=0 -> IDLE, flags clear. MEMHold=1 -> stay DONE, all outputs held.
//  Read latency: access seen in IDLE cycle 0, mem_req from cycle 1, DONE one cycle after ack.
//   Min 3 cycles of MEMStall-inclusive occupancy.
//  Byte enables/data (o=addr[1:0]):
//   SB: be=4'b0001<<o, wdata={4{d[7:0]}}.
//   SH: be=o[1]?4'b1100:4'b0011, wdata={2{d[15:0]}}.
//   SW: be=4'b1111, wdata=d.
//   Loads drive be=4'b1111.
//  Load extend:
//   LB/LBU: byte rdata[8o+:8], sign/zero extended.
//   LH/LHU: half rdata[16*o[1]+:16], sign/zero extended.
//   LW: rdata unchanged.
//  Stores never modify MemoryData. MemRead and MemWrite both high: treated as illegal.
// TESTING
//  LW 0x100, ack 3 cycles after req, rdata 0xDEADBEEF -> mem_req 3 cycles, addr 0x100, be 1111;
//   MemoryData=0xDEADBEEF in DONE; MEMStall high 4 cycles.
//  LB 0x103, rdata 0x80112233 -> MemoryData 0xFFFFFF80.
//   LBU same -> 0x00000080; LHU 0x102 -> 0x00008011.
//  SH 0x102, data 0x1234ABCD -> mem_we=1, addr 0x100, be 1100, wdata 0xABCDABCD; MemoryData unchanged.
//  LW 0x101 -> no mem_req; MisalignErr=1 for 1 cycle (DONE); MEMStall=1 for 1 cycle only.
//  TIMEOUT_CYCLES=4, ack never -> mem_req 4 cycles then 0; BusTimeout=1, MemoryData=0.
//   Late ack while mem_req=0 is ignored.
//  rst=0 in 2nd BUSY cycle -> mem_req, MEMStall, flags 0 without clock edge.
//   After release, back-to-back SW then LW both complete in order.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: EX/MEM controls -> req/ack data-bus cycle, extended load data, stall and error flags.
// Latency: access seen in IDLE, mem_req from next cycle, DONE one cycle after mem_ack; MEMHold parks the unit in DONE.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EXMEMMemRead,
  input  logic        EXMEMMemWrite,
  input  logic [2:0]  EXMEMFunct3,
  input  logic [31:0] EXMEMALUResult,
  input  logic [31:0] EXMEMWriteData,
  input  logic        MEMHold,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] MemoryData,
  output logic        MEMStall,
  output logic        MisalignErr,
  output logic        BusTimeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, mem_data_q, ld_ext;
  logic [2:0]  f3_q;
  logic        we_q, misal_q, tmo_q;
  logic [3:0]  be_q, be_calc;
  logic [7:0]  cnt;
  logic [31:0] wdata_calc;
  logic [1:0]  off_in, off_q;
  logic [7:0]  rb;
  logic [15:0] rh;
  logic        access, bad_f3, misal, legal, timeout_hit;

  // Decode of the incoming access: legality, alignment, lane steering.
  always_comb begin
    access     = EXMEMMemRead | EXMEMMemWrite;
    off_in     = EXMEMALUResult[1:0];
    bad_f3     = (EXMEMFunct3 == 3'b011) || (EXMEMFunct3[2:1] == 2'b11) ||
                 (EXMEMMemWrite && EXMEMFunct3[2]) || (EXMEMMemRead && EXMEMMemWrite);
    misal      = ((EXMEMFunct3[1:0] == 2'b01) && off_in[0]) ||
                 ((EXMEMFunct3[1:0] == 2'b10) && (off_in != 2'b00));
    legal      = !bad_f3 && !misal;
    be_calc    = 4'b1111;
    wdata_calc = EXMEMWriteData;
    if (EXMEMMemWrite) begin
      case (EXMEMFunct3[1:0])
        2'b00: begin
          be_calc    = 4'b0001 << off_in;
          wdata_calc = {4{EXMEMWriteData[7:0]}};
        end
        2'b01: begin
          be_calc    = off_in[1] ? 4'b1100 : 4'b0011;
          wdata_calc = {2{EXMEMWriteData[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    off_q = addr_q[1:0];
    rb    = mem_rdata[{off_q, 3'b000} +: 8];
    rh    = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_ext = {{24{rb[7]}}, rb};
      3'b100:  ld_ext = {24'h0, rb};
      3'b001:  ld_ext = {{16{rh[15]}}, rh};
      3'b101:  ld_ext = {16'h0, rh};
      default: ld_ext = mem_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (access) state_nxt = legal ? BUSY : DONE;
      BUSY: if (mem_ack || timeout_hit) state_nxt = DONE;
      DONE: if (!MEMHold) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      cnt        <= '0;
      mem_data_q <= '0;
      misal_q    <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (access) begin
            addr_q  <= EXMEMALUResult;
            wdata_q <= wdata_calc;
            f3_q    <= EXMEMFunct3;
            we_q    <= EXMEMMemWrite;
            be_q    <= be_calc;
            misal_q <= !legal;
          end
        end
        BUSY: begin
          cnt <= cnt + 8'd1;
          // An ack arriving on the timeout cycle still completes normally.
          if (mem_ack) begin
            if (!we_q) mem_data_q <= ld_ext;
          end else if (timeout_hit) begin
            mem_data_q <= '0;
            tmo_q      <= 1'b1;
          end
        end
        DONE: begin
          if (!MEMHold) begin
            misal_q <= 1'b0;
            tmo_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req     = (state == BUSY);
  assign MEMStall    = rst && (((state == IDLE) && access) || (state == BUSY));
  assign mem_we      = we_q;
  assign mem_addr    = {addr_q[31:2], 2'b00};
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;
  assign MemoryData  = mem_data_q;
  assign MisalignErr = misal_q;
  assign BusTimeout  = tmo_q;

endmodule
